// File: rtl/proc_ctrl_pkg.sv
// proc_ctrl_pkg: shared types and helpers for the processor control unit.
//   state_e    - controller state encoding (4 bits, INIT = 0)
//   opcode_e   - legal opcodes; anything numerically above OP_JZ is illegal
//   rf_sel_e   - register-file write-data mux select
//   alu_fn_e   - ALU function select
//   get_field  - extract an instruction field
//   op_to_state- execute state entered from DECODE for a given opcode
package proc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_INIT   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_NOOP   = 4'd3,
    ST_STORE  = 4'd4,
    ST_LOAD_A = 4'd5,
    ST_LOAD_B = 4'd6,
    ST_ALU    = 4'd7,
    ST_LDI    = 4'd8,
    ST_JZ     = 4'd9,
    ST_HALT   = 4'd10,
    ST_FAULT  = 4'd11
  } state_e;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'd0,
    OP_STORE = 4'd1,
    OP_LOAD  = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_HALT  = 4'd5,
    OP_LDI   = 4'd6,
    OP_JZ    = 4'd7
  } opcode_e;

  typedef enum logic [1:0] {
    RFS_ALU = 2'd0,
    RFS_MEM = 2'd1,
    RFS_IMM = 2'd2
  } rf_sel_e;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2
  } alu_fn_e;

  // Fields are returned zero-extended to 64 bits so the helper is usable
  // for any parameterisation; callers slice the width they need.
  function automatic logic [63:0] get_field(input logic [63:0] ir,
                                            input int unsigned lsb,
                                            input int unsigned width);
    logic [63:0] mask;
    mask = (64'd1 << width) - 64'd1;
    return (ir >> lsb) & mask;
  endfunction

  function automatic state_e op_to_state(input logic [63:0] op);
    state_e st;
    case (op)
      64'(OP_NOOP):  st = ST_NOOP;
      64'(OP_STORE): st = ST_STORE;
      64'(OP_LOAD):  st = ST_LOAD_A;
      64'(OP_ADD):   st = ST_ALU;
      64'(OP_SUB):   st = ST_ALU;
      64'(OP_HALT):  st = ST_HALT;
      64'(OP_LDI):   st = ST_LDI;
      64'(OP_JZ):    st = ST_JZ;
      default:       st = ST_FAULT;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/proc_ctrl_unit_wait.sv
// proc_ctrl_wait: data-memory read-latency down-counter.
//   clk, rst_n - clock, asynchronous active-low reset
//   load       - preset the counter to MEM_LAT-1
//   en         - count down (held at zero once reached)
//   done       - counter is zero: the final wait cycle
module proc_ctrl_wait #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(MEM_LAT - 1);
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/proc_ctrl_unit.sv
// proc_ctrl_unit: multi-cycle fetch/decode/execute controller.
//   Clk, Reset_n           - clock, asynchronous active-low reset
//   Instruction            - instruction register contents
//   RF_Ra_Zero             - RF A-port data is zero (JZ condition)
//   Resume                 - leave HALT / FAULT
//   PC_Clr/Up/Ld, PC_Target- program counter control
//   IR_ld                  - load instruction register
//   D_Addr, D_wr           - data memory address / write enable
//   RF_*                   - register-file addresses, write enable, mux, imm
//   ALU_s0                 - ALU function select
//   Halted, Fault          - status flags
//   OutState, NextState    - current / next controller state
//   InstrCount             - saturating retired-instruction count
module proc_ctrl_unit
  import proc_ctrl_pkg::*;
#(
  parameter int unsigned OPW     = 4,
  parameter int unsigned RAW     = 4,
  parameter int unsigned DAW     = 8,
  parameter int unsigned IW      = 16,
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned CNTW    = 16
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic [IW-1:0]   Instruction,
  input  logic            RF_Ra_Zero,
  input  logic            Resume,
  output logic            PC_Clr,
  output logic            PC_Up,
  output logic            PC_Ld,
  output logic [DAW-1:0]  PC_Target,
  output logic            IR_ld,
  output logic [DAW-1:0]  D_Addr,
  output logic            D_wr,
  output logic [RAW-1:0]  RF_Ra_Addr,
  output logic [RAW-1:0]  RF_Rb_Addr,
  output logic [RAW-1:0]  RF_W_Addr,
  output logic            RF_W_en,
  output logic [1:0]      RF_s,
  output logic [DAW-1:0]  RF_Imm,
  output logic [2:0]      ALU_s0,
  output logic            Halted,
  output logic            Fault,
  output logic [3:0]      OutState,
  output logic [3:0]      NextState,
  output logic [CNTW-1:0] InstrCount
);

  logic [63:0]    ir_ext;
  logic [63:0]    op_w, f2_w, f1_w, f0_w, hi_w, lo_w;
  logic [RAW-1:0] f2, f1, f0;
  logic [DAW-1:0] hi, lo;
  logic           unused_field_bits;

  always_comb begin
    ir_ext = 64'(Instruction);
    op_w   = get_field(ir_ext, 3 * RAW, OPW);
    f2_w   = get_field(ir_ext, 2 * RAW, RAW);
    f1_w   = get_field(ir_ext, RAW, RAW);
    f0_w   = get_field(ir_ext, 0, RAW);
    hi_w   = get_field(ir_ext, RAW, DAW);
    lo_w   = get_field(ir_ext, 0, DAW);
    f2     = f2_w[RAW-1:0];
    f1     = f1_w[RAW-1:0];
    f0     = f0_w[RAW-1:0];
    hi     = hi_w[DAW-1:0];
    lo     = lo_w[DAW-1:0];
  end

  assign unused_field_bits = ^{f2_w[63:RAW], f1_w[63:RAW], f0_w[63:RAW],
                               hi_w[63:DAW], lo_w[63:DAW]};

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            wait_load, wait_en, wait_done;
  logic            retire;

  proc_ctrl_wait #(
    .MEM_LAT(MEM_LAT)
  ) u_wait (
    .clk  (Clk),
    .rst_n(Reset_n),
    .load (wait_load),
    .en   (wait_en),
    .done (wait_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:   state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: state_d = op_to_state(op_w);
      ST_LOAD_A: if (wait_done) state_d = ST_LOAD_B;
      ST_NOOP, ST_STORE, ST_LOAD_B, ST_ALU, ST_LDI, ST_JZ:
                 state_d = ST_FETCH;
      ST_HALT, ST_FAULT:
                 if (Resume) state_d = ST_FETCH;
      default:   state_d = ST_INIT;
    endcase
  end

  assign wait_load = (state_q == ST_DECODE) && (state_d == ST_LOAD_A);
  assign wait_en   = (state_q == ST_LOAD_A);

  // Execute states always exit to FETCH, so being in one is a retirement;
  // HALT retires on entry instead, FAULT never does.
  always_comb begin
    retire = 1'b0;
    case (state_q)
      ST_NOOP, ST_STORE, ST_LOAD_B, ST_ALU, ST_LDI, ST_JZ: retire = 1'b1;
      ST_DECODE: retire = (state_d == ST_HALT);
      default:   retire = 1'b0;
    endcase
    cnt_d = cnt_q;
    if (retire && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    PC_Clr     = 1'b0;
    PC_Up      = 1'b0;
    PC_Ld      = 1'b0;
    PC_Target  = '0;
    IR_ld      = 1'b0;
    D_Addr     = '0;
    D_wr       = 1'b0;
    RF_Ra_Addr = '0;
    RF_Rb_Addr = '0;
    RF_W_Addr  = '0;
    RF_W_en    = 1'b0;
    RF_s       = RFS_ALU;
    RF_Imm     = '0;
    ALU_s0     = ALU_PASS;
    Halted     = 1'b0;
    Fault      = 1'b0;
    case (state_q)
      ST_INIT:  PC_Clr = 1'b1;
      ST_FETCH: begin
        IR_ld = 1'b1;
        PC_Up = 1'b1;
      end
      ST_STORE: begin
        RF_Ra_Addr = f2;
        D_Addr     = lo;
        D_wr       = 1'b1;
      end
      ST_LOAD_A: D_Addr = hi;
      ST_LOAD_B: begin
        D_Addr    = hi;
        RF_W_Addr = f0;
        RF_s      = RFS_MEM;
        RF_W_en   = 1'b1;
      end
      ST_ALU: begin
        RF_Ra_Addr = f2;
        RF_Rb_Addr = f1;
        RF_W_Addr  = f0;
        RF_W_en    = 1'b1;
        RF_s       = RFS_ALU;
        ALU_s0     = (op_w == 64'(OP_SUB)) ? ALU_SUB : ALU_ADD;
      end
      ST_LDI: begin
        RF_Imm    = hi;
        RF_W_Addr = f0;
        RF_W_en   = 1'b1;
        RF_s      = RFS_IMM;
      end
      ST_JZ: begin
        RF_Ra_Addr = f2;
        PC_Target  = lo;
        PC_Ld      = RF_Ra_Zero;
      end
      ST_HALT:  Halted = 1'b1;
      ST_FAULT: Fault  = 1'b1;
      default: ;
    endcase
  end

  // NextState reads INIT while reset is held so every output but PC_Clr is
  // zero during reset; once released INIT advances to FETCH.
  assign OutState   = state_q;
  assign NextState  = Reset_n ? state_d : ST_INIT;
  assign InstrCount = cnt_q;

endmodule

// File: tb/tb_proc_ctrl_unit.sv
module tb_proc_ctrl_unit;

  localparam logic [3:0] S_INIT = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2,
                         S_NOOP = 4'd3, S_STORE = 4'd4, S_LOAD_A = 4'd5,
                         S_LOAD_B = 4'd6, S_ALU = 4'd7, S_LDI = 4'd8,
                         S_JZ = 4'd9, S_HALT = 4'd10, S_FAULT = 4'd11;

  typedef struct packed {
    logic [3:0]  st;
    logic [3:0]  nx;
    logic        pc_clr;
    logic        pc_up;
    logic        pc_ld;
    logic [7:0]  pc_tgt;
    logic        ir_ld;
    logic [7:0]  d_addr;
    logic        d_wr;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  wa;
    logic        w_en;
    logic [1:0]  rf_s;
    logic [7:0]  imm;
    logic [2:0]  alu;
    logic        halted;
    logic        fault;
    logic [15:0] cnt;
  } obs_t;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        rst_n  [2];
  logic [15:0] instr  [2];
  logic        zero   [2];
  logic        resume [2];

  // DUT A: MEM_LAT=3, CNTW=16
  logic a_pc_clr, a_pc_up, a_pc_ld, a_ir_ld, a_d_wr, a_w_en, a_halted, a_fault;
  logic [7:0] a_pc_tgt, a_d_addr, a_imm;
  logic [3:0] a_ra, a_rb, a_wa, a_st, a_nx;
  logic [1:0] a_rf_s;
  logic [2:0] a_alu;
  logic [15:0] a_cnt;

  proc_ctrl_unit #(
    .OPW(4), .RAW(4), .DAW(8), .IW(16), .MEM_LAT(3), .CNTW(16)
  ) dut_a (
    .Clk(Clk), .Reset_n(rst_n[0]), .Instruction(instr[0]),
    .RF_Ra_Zero(zero[0]), .Resume(resume[0]),
    .PC_Clr(a_pc_clr), .PC_Up(a_pc_up), .PC_Ld(a_pc_ld), .PC_Target(a_pc_tgt),
    .IR_ld(a_ir_ld), .D_Addr(a_d_addr), .D_wr(a_d_wr),
    .RF_Ra_Addr(a_ra), .RF_Rb_Addr(a_rb), .RF_W_Addr(a_wa), .RF_W_en(a_w_en),
    .RF_s(a_rf_s), .RF_Imm(a_imm), .ALU_s0(a_alu),
    .Halted(a_halted), .Fault(a_fault),
    .OutState(a_st), .NextState(a_nx), .InstrCount(a_cnt)
  );

  // DUT B: MEM_LAT=1, CNTW=2 (saturation and single-cycle load wait)
  logic b_pc_clr, b_pc_up, b_pc_ld, b_ir_ld, b_d_wr, b_w_en, b_halted, b_fault;
  logic [7:0] b_pc_tgt, b_d_addr, b_imm;
  logic [3:0] b_ra, b_rb, b_wa, b_st, b_nx;
  logic [1:0] b_rf_s;
  logic [2:0] b_alu;
  logic [1:0] b_cnt;

  proc_ctrl_unit #(
    .OPW(4), .RAW(4), .DAW(8), .IW(16), .MEM_LAT(1), .CNTW(2)
  ) dut_b (
    .Clk(Clk), .Reset_n(rst_n[1]), .Instruction(instr[1]),
    .RF_Ra_Zero(zero[1]), .Resume(resume[1]),
    .PC_Clr(b_pc_clr), .PC_Up(b_pc_up), .PC_Ld(b_pc_ld), .PC_Target(b_pc_tgt),
    .IR_ld(b_ir_ld), .D_Addr(b_d_addr), .D_wr(b_d_wr),
    .RF_Ra_Addr(b_ra), .RF_Rb_Addr(b_rb), .RF_W_Addr(b_wa), .RF_W_en(b_w_en),
    .RF_s(b_rf_s), .RF_Imm(b_imm), .ALU_s0(b_alu),
    .Halted(b_halted), .Fault(b_fault),
    .OutState(b_st), .NextState(b_nx), .InstrCount(b_cnt)
  );

  obs_t obs_a, obs_b;
  always_comb begin
    obs_a = '{st: a_st, nx: a_nx, pc_clr: a_pc_clr, pc_up: a_pc_up,
              pc_ld: a_pc_ld, pc_tgt: a_pc_tgt, ir_ld: a_ir_ld,
              d_addr: a_d_addr, d_wr: a_d_wr, ra: a_ra, rb: a_rb, wa: a_wa,
              w_en: a_w_en, rf_s: a_rf_s, imm: a_imm, alu: a_alu,
              halted: a_halted, fault: a_fault, cnt: a_cnt};
    obs_b = '{st: b_st, nx: b_nx, pc_clr: b_pc_clr, pc_up: b_pc_up,
              pc_ld: b_pc_ld, pc_tgt: b_pc_tgt, ir_ld: b_ir_ld,
              d_addr: b_d_addr, d_wr: b_d_wr, ra: b_ra, rb: b_rb, wa: b_wa,
              w_en: b_w_en, rf_s: b_rf_s, imm: b_imm, alu: b_alu,
              halted: b_halted, fault: b_fault, cnt: 16'(b_cnt)};
  end

  // Expected per-cycle output vectors, one queue per DUT.
  obs_t  exp_q [2][$];
  string tag_q [2][$];
  int    n_vec = 0;
  int    n_err = 0;

  int unsigned cnt_m   [2];
  int unsigned cnt_max [2] = '{65535, 3};
  int          lat     [2] = '{3, 1};

  always @(negedge Clk) begin
    for (int d = 0; d < 2; d++) begin
      if (exp_q[d].size() > 0) begin
        obs_t  e, g;
        string t;
        e = exp_q[d].pop_front();
        t = tag_q[d].pop_front();
        g = (d == 0) ? obs_a : obs_b;
        n_vec++;
        if (g !== e) begin
          n_err++;
          $display("FAIL dut%0d %s @%0t: got st=%0d nx=%0d vec=%h, want st=%0d nx=%0d vec=%h",
                   d, t, $time, g.st, g.nx, g, e.st, e.nx, e);
        end
      end
    end
  end

  function automatic obs_t rec(input logic [3:0] st, input logic [3:0] nx,
                               input int unsigned c);
    obs_t r;
    r     = '0;
    r.st  = st;
    r.nx  = nx;
    r.cnt = 16'(c);
    return r;
  endfunction

  task automatic cycle(input int d, input obs_t r, input string tag);
    exp_q[d].push_back(r);
    tag_q[d].push_back(tag);
    @(posedge Clk);
    #1;
  endtask

  task automatic retire(input int d);
    if (cnt_m[d] < cnt_max[d]) cnt_m[d]++;
  endtask

  task automatic lit(input string name, input int got, input int want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic do_reset(input int d, input int n);
    obs_t r;
    rst_n[d]  = 1'b0;
    resume[d] = 1'b0;
    cnt_m[d]  = 0;
    for (int i = 0; i < n; i++) begin
      r = rec(S_INIT, S_INIT, 0);
      r.pc_clr = 1'b1;
      cycle(d, r, "reset");
    end
    rst_n[d] = 1'b1;
    r = rec(S_INIT, S_FETCH, 0);
    r.pc_clr = 1'b1;
    cycle(d, r, "init");
  endtask

  task automatic fetch_decode(input int d, input logic [15:0] ir,
                              input logic [3:0] exec_st);
    obs_t r;
    r = rec(S_FETCH, S_DECODE, cnt_m[d]);
    r.ir_ld = 1'b1;
    r.pc_up = 1'b1;
    cycle(d, r, "fetch");
    r = rec(S_DECODE, exec_st, cnt_m[d]);
    cycle(d, r, $sformatf("decode_%h", ir));
  endtask

  // Run one instruction from FETCH back to the next FETCH.
  // hold: number of HALT/FAULT cycles with Resume low before the Resume pulse.
  task automatic exec(input int d, input logic [15:0] ir, input logic z,
                      input logic rs, input int hold);
    obs_t r;
    logic [3:0] op, f2, f1, f0;
    logic [7:0] hi, lo;
    logic [3:0] es;
    op = ir[15:12]; f2 = ir[11:8]; f1 = ir[7:4]; f0 = ir[3:0];
    hi = ir[11:4];  lo = ir[7:0];
    instr[d] = ir; zero[d] = z; resume[d] = rs;
    case (op)
      4'd0: es = S_NOOP;
      4'd1: es = S_STORE;
      4'd2: es = S_LOAD_A;
      4'd3, 4'd4: es = S_ALU;
      4'd5: es = S_HALT;
      4'd6: es = S_LDI;
      4'd7: es = S_JZ;
      default: es = S_FAULT;
    endcase
    fetch_decode(d, ir, es);
    r = rec(es, S_FETCH, cnt_m[d]);
    case (es)
      S_NOOP: begin
        cycle(d, r, "noop");
        retire(d);
      end
      S_STORE: begin
        r.ra = f2; r.d_addr = lo; r.d_wr = 1'b1;
        cycle(d, r, "store");
        retire(d);
      end
      S_LOAD_A: begin
        for (int i = 0; i < lat[d]; i++) begin
          r = rec(S_LOAD_A, (i == lat[d] - 1) ? S_LOAD_B : S_LOAD_A, cnt_m[d]);
          r.d_addr = hi;
          cycle(d, r, "load_a");
        end
        r = rec(S_LOAD_B, S_FETCH, cnt_m[d]);
        r.d_addr = hi; r.wa = f0; r.rf_s = 2'd1; r.w_en = 1'b1;
        cycle(d, r, "load_b");
        retire(d);
      end
      S_ALU: begin
        r.ra = f2; r.rb = f1; r.wa = f0; r.w_en = 1'b1; r.rf_s = 2'd0;
        r.alu = (op == 4'd4) ? 3'd2 : 3'd1;
        cycle(d, r, "alu");
        retire(d);
      end
      S_LDI: begin
        r.imm = hi; r.wa = f0; r.w_en = 1'b1; r.rf_s = 2'd2;
        cycle(d, r, "ldi");
        retire(d);
      end
      S_JZ: begin
        r.ra = f2; r.pc_tgt = lo; r.pc_ld = z;
        cycle(d, r, "jz");
        retire(d);
      end
      default: begin
        if (es == S_HALT) retire(d);
        resume[d] = 1'b0;
        for (int i = 0; i < hold; i++) begin
          r = rec(es, es, cnt_m[d]);
          r.halted = (es == S_HALT);
          r.fault  = (es == S_FAULT);
          cycle(d, r, "hold");
        end
        resume[d] = 1'b1;
        r = rec(es, S_FETCH, cnt_m[d]);
        r.halted = (es == S_HALT);
        r.fault  = (es == S_FAULT);
        cycle(d, r, "resume");
      end
    endcase
    resume[d] = 1'b0;
  endtask

  task automatic exec_abort_load(input int d, input logic [15:0] ir);
    obs_t r;
    instr[d] = ir; zero[d] = 1'b0; resume[d] = 1'b0;
    fetch_decode(d, ir, S_LOAD_A);
    r = rec(S_LOAD_A, S_LOAD_A, cnt_m[d]);
    r.d_addr = ir[11:4];
    cycle(d, r, "load_a_pre_abort");
    do_reset(d, 1);
  endtask

  int sat_exp [5] = '{1, 2, 3, 3, 3};

  initial begin
    rst_n  = '{1'b0, 1'b0};
    instr  = '{16'h0000, 16'h0000};
    zero   = '{1'b0, 1'b0};
    resume = '{1'b0, 1'b0};
    cnt_m  = '{0, 0};
    @(posedge Clk);
    #1;

    do_reset(0, 2);
    exec(0, 16'h0000, 1'b0, 1'b0, 0); lit("cnt_noop", int'(a_cnt), 1);
    exec(0, 16'h2123, 1'b0, 1'b0, 0); lit("cnt_load", int'(a_cnt), 2);
    exec(0, 16'h3012, 1'b0, 1'b1, 0); lit("cnt_add", int'(a_cnt), 3);
    exec(0, 16'h4324, 1'b0, 1'b0, 0); lit("cnt_sub", int'(a_cnt), 4);
    exec(0, 16'h1A5C, 1'b0, 1'b1, 0); lit("cnt_store", int'(a_cnt), 5);
    exec(0, 16'h6A57, 1'b0, 1'b0, 0); lit("cnt_ldi", int'(a_cnt), 6);
    exec(0, 16'h7109, 1'b1, 1'b0, 0); lit("cnt_jz_taken", int'(a_cnt), 7);
    exec(0, 16'h7109, 1'b0, 1'b0, 0); lit("cnt_jz_not", int'(a_cnt), 8);
    exec(0, 16'hF000, 1'b0, 1'b0, 2); lit("cnt_fault", int'(a_cnt), 8);
    exec(0, 16'h8000, 1'b0, 1'b0, 0); lit("cnt_fault8", int'(a_cnt), 8);
    exec(0, 16'h5000, 1'b0, 1'b0, 2); lit("cnt_halt", int'(a_cnt), 9);
    exec_abort_load(0, 16'h2123);     lit("cnt_abort", int'(a_cnt), 0);
    exec(0, 16'h0000, 1'b0, 1'b0, 0);
    exec(0, 16'h2345, 1'b0, 1'b0, 0); lit("cnt_post_abort", int'(a_cnt), 2);

    do_reset(1, 1);
    for (int i = 0; i < 5; i++) begin
      exec(1, 16'h0000, 1'b0, 1'b0, 0);
      lit($sformatf("cnt_sat_%0d", i), int'(b_cnt), sat_exp[i]);
    end
    exec(1, 16'h2123, 1'b0, 1'b0, 0);
    exec(1, 16'h5000, 1'b0, 1'b0, 1); lit("cnt_sat_halt", int'(b_cnt), 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
